temp_guard: RTL and testbench
=============================

# temp_guard

Thermal policy stage fed by the on-chip temperature poller. It takes each new 8-bit Celsius reading and keeps a 4-sample moving average. From that average it runs a COOL/WARM/HOT state machine with hysteresis, drives a PWM fan output and raises a latched overheat flag. The averaged value is also exported for the seven-segment display.

## Interface
Parameters:
- WARN_THRESH, 70: average (°C) at or above which the block enters WARM.
- TRIP_THRESH, 85: average (°C) at or above which the block enters HOT. Must be greater than WARN_THRESH.
- HYST, 5: hysteresis (°C) applied on downward transitions. Must not exceed WARN_THRESH.
- DUTY_COOL, 64: fan duty out of 256 in COOL.
- DUTY_WARM, 160: fan duty out of 256 in WARM.

Ports:
- clk_50mhz  in  1  system clock. One clock domain only; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle pulse when a new reading is available.
- sample_val  in  8  reading in °C, unsigned. Qualified by sample_valid.
- trip_clear  in  1  level input; requests exit from HOT.
- avg_temp  out  8  current 4-sample average.
- avg_valid  out  1  one-cycle pulse on each avg_temp update.
- fan_pwm  out  1  fan drive, active high.
- overheat  out  1  high while in HOT.
- stale  out  1  watchdog flag. Tied to 0 unless TEMP_GUARD_WATCHDOG_EN is defined.

## Operation
- History buffer: 4 × 8-bit entries plus a 10-bit running sum. avg_temp = sum[9:2], truncated.
- First sample after reset: all 4 entries and the sum are loaded from that sample, so avg_temp equals the sample.
- Later samples: the oldest entry is shifted out. sum = sum − oldest + new. No overflow is possible at 10 bits.
- State machine (registered). States: COOL, WARM, HOT.
  - COOL → WARM when avg_temp ≥ WARN_THRESH.
  - COOL → HOT directly when avg_temp ≥ TRIP_THRESH.
  - WARM → COOL when avg_temp < WARN_THRESH − HYST.
  - WARM → HOT when avg_temp ≥ TRIP_THRESH.
  - HOT is sticky. HOT → WARM only on a cycle where trip_clear = 1 and avg_temp < TRIP_THRESH − HYST. The following avg update may then drop the state to COOL.
  - COOL/WARM transitions are evaluated only in the cycle after avg_valid. The HOT exit is evaluated every cycle.
- Duty: COOL → DUTY_COOL; WARM → DUTY_WARM; HOT → 256 (fan constantly high).
- PWM: 8-bit free-running counter. fan_pwm = registered (cnt < duty), forced to 1 in HOT.
- overheat = (state == HOT), registered.

## Timing
- Reset values: avg_temp 0, avg_valid 0, fan_pwm 0, overheat 0, stale 0, state COOL, history empty (first-sample flag set), PWM counter 0.
- Latency:
  - sample_valid at cycle N → avg_temp and avg_valid at N+1.
  - State and overheat at N+2.
  - fan_pwm reflects the new duty from N+3.
- Back-to-back sample_valid on consecutive cycles must be accepted with no loss.
- Simultaneous events:
  - Cycle after avg_valid with trip_clear asserted while in HOT: the HOT exit uses the just-updated avg_temp. A single cycle never moves more than one state.
  - Re-entry check wins: if the state is HOT, trip_clear = 1 and avg_temp ≥ TRIP_THRESH, the state remains HOT.
- Reset mid-operation: all history is discarded. The next sample is treated as the first.
- PWM counter wraps 255 → 0. The duty change takes effect immediately, not at the period boundary.

## Configuration
- TEMP_GUARD_WATCHDOG_EN defined:
  - A 27-bit counter clears on every sample_valid and saturates at 2^27−1 (~2.7 s at 50 MHz).
  - At saturation, stale = 1 and fan_pwm is forced to 1. overheat and the state machine are unaffected.
  - The next sample_valid clears stale on the following cycle.
  - The counter also clears on reset.
- Macro undefined: no counter; stale is constant 0.

## Test plan
- Reset, then a single sample of 40 → avg_temp = 40 and avg_valid pulse one cycle later; state COOL; fan_pwm high 64 of every 256 cycles.
- Samples 40, 80, 80, 80 → averages 40, 50, 60, 70; state WARM two cycles after the fourth sample; duty 160.
- Drive the average to 90 → HOT, overheat = 1, fan_pwm constant 1.
  - Samples of 82 with trip_clear = 1 → no exit until avg < 80; then WARM.
  - trip_clear = 0 → stays HOT indefinitely.
- From WARM at avg 70: lower the average to 66 → stays WARM; lower to 64 → COOL.
- Assert reset while in HOT → all outputs return to reset values next cycle; next sample of 30 gives avg_temp = 30.
- With TEMP_GUARD_WATCHDOG_EN: no samples for 2^27 cycles → stale = 1 and fan_pwm = 1; one sample_valid → stale = 0 the next cycle.

Source files
------------

// File: rtl/temp_guard_if.sv
// Temperature sample stream into temp_guard and its policy outputs back to the system.
interface temp_guard_if;
  logic       sample_valid;
  logic [7:0] sample_val;
  logic       trip_clear;
  logic [7:0] avg_temp;
  logic       avg_valid;
  logic       fan_pwm;
  logic       overheat;
  logic       stale;

  modport master (
    output sample_valid, sample_val, trip_clear,
    input  avg_temp, avg_valid, fan_pwm, overheat, stale
  );

  modport slave (
    input  sample_valid, sample_val, trip_clear,
    output avg_temp, avg_valid, fan_pwm, overheat, stale
  );
endinterface

// File: rtl/temp_guard.sv
// Thermal policy: 4-sample average (N+1), COOL/WARM/HOT hysteresis FSM (N+2), fan PWM (N+3); no backpressure.
// Optional sample watchdog (stale flag, forced fan) built only with TEMP_GUARD_WATCHDOG_EN.
module temp_guard #(
  parameter int WARN_THRESH = 70,
  parameter int TRIP_THRESH = 85,
  parameter int HYST        = 5,
  parameter int DUTY_COOL   = 64,
  parameter int DUTY_WARM   = 160
) (
  input  logic         clk_50mhz,
  input  logic         reset,
  temp_guard_if.slave  tg
);

  typedef enum logic [1:0] {ST_COOL, ST_WARM, ST_HOT} state_t;

  localparam logic [7:0] WARN_HI = 8'(WARN_THRESH);
  localparam logic [7:0] WARN_LO = 8'(WARN_THRESH - HYST);
  localparam logic [7:0] TRIP_HI = 8'(TRIP_THRESH);
  localparam logic [7:0] TRIP_LO = 8'(TRIP_THRESH - HYST);
  localparam logic [8:0] DUTY_C  = 9'(DUTY_COOL);
  localparam logic [8:0] DUTY_W  = 9'(DUTY_WARM);
  localparam logic [8:0] DUTY_H  = 9'd256;

  logic [3:0][7:0] hist_q, hist_d;
  logic [9:0]      sum_q, sum_d;
  logic            first_q, first_d;
  logic            avg_valid_q;
  state_t          state_q, state_d;
  logic            overheat_q;
  logic [7:0]      cnt_q;
  logic [8:0]      duty;
  logic            fan_pwm_q, fan_pwm_d;
  logic [7:0]      avg;
  logic            stale_w;

  assign avg = sum_q[9:2];

  // hist_q[3] is the oldest entry; the first sample after reset fills every slot.
  always_comb begin
    hist_d  = hist_q;
    sum_d   = sum_q;
    first_d = first_q;
    if (tg.sample_valid) begin
      if (first_q) begin
        hist_d  = {4{tg.sample_val}};
        sum_d   = {tg.sample_val, 2'b00};
        first_d = 1'b0;
      end else begin
        hist_d = {hist_q[2:0], tg.sample_val};
        sum_d  = sum_q - {2'b00, hist_q[3]} + {2'b00, tg.sample_val};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COOL: begin
        if (avg_valid_q) begin
          if (avg >= TRIP_HI)      state_d = ST_HOT;
          else if (avg >= WARN_HI) state_d = ST_WARM;
        end
      end
      ST_WARM: begin
        if (avg_valid_q) begin
          if (avg >= TRIP_HI)     state_d = ST_HOT;
          else if (avg < WARN_LO) state_d = ST_COOL;
        end
      end
      ST_HOT: begin
        if (tg.trip_clear && (avg < TRIP_LO)) state_d = ST_WARM;
      end
      default: state_d = ST_COOL;
    endcase
  end

  always_comb begin
    duty = DUTY_C;
    case (state_q)
      ST_WARM: duty = DUTY_W;
      ST_HOT:  duty = DUTY_H;
      default: duty = DUTY_C;
    endcase
    fan_pwm_d = (state_q == ST_HOT) || ({1'b0, cnt_q} < duty);
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      hist_q      <= '0;
      sum_q       <= '0;
      first_q     <= 1'b1;
      avg_valid_q <= 1'b0;
      state_q     <= ST_COOL;
      overheat_q  <= 1'b0;
      cnt_q       <= '0;
      fan_pwm_q   <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      sum_q       <= sum_d;
      first_q     <= first_d;
      avg_valid_q <= tg.sample_valid;
      state_q     <= state_d;
      overheat_q  <= (state_d == ST_HOT);
      cnt_q       <= cnt_q + 8'd1;
      fan_pwm_q   <= fan_pwm_d;
    end
  end

`ifdef TEMP_GUARD_WATCHDOG_EN
  localparam logic [26:0] WD_MAX = '1;

  logic [26:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (tg.sample_valid)    wd_d = '0;
    else if (wd_q != WD_MAX) wd_d = wd_q + 27'd1;
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end

  assign stale_w = (wd_q == WD_MAX);
`else
  assign stale_w = 1'b0;
`endif

  assign tg.avg_temp  = avg;
  assign tg.avg_valid = avg_valid_q;
  assign tg.overheat  = overheat_q;
  assign tg.stale     = stale_w;
  assign tg.fan_pwm   = fan_pwm_q | stale_w;

endmodule

// File: tb/tb_temp_guard.sv
// Directed bench for temp_guard: averaging, hysteresis FSM, sticky HOT exit, PWM duty and mid-run reset.
module tb_temp_guard;

  logic clk_50mhz = 1'b0;
  logic reset;

  always #10 clk_50mhz = ~clk_50mhz;

  temp_guard_if tg();

  temp_guard dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .tg        (tg)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_b2b [3] = '{8'd50, 8'd60, 8'd70};
  logic [7:0] exp_hot [4] = '{8'd66, 8'd69, 8'd85, 8'd90};
  logic [7:0] exp_clr [4] = '{8'd88, 8'd86, 8'd84, 8'd82};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns in the cycle after the sample, where the new average must be visible.
  task automatic send(input logic [7:0] v, input logic [7:0] exp_avg, input string tag);
    tg.sample_val   = v;
    tg.sample_valid = 1'b1;
    @(negedge clk_50mhz);
    tg.sample_valid = 1'b0;
    chk({tag, "_avg_valid"}, 32'(tg.avg_valid), 32'd1);
    chk({tag, "_avg"}, 32'(tg.avg_temp), 32'(exp_avg));
  endtask

  task automatic pwm_count(input int exp, input string tag);
    int n;
    n = 0;
    repeat (2) @(negedge clk_50mhz);
    repeat (256) begin
      @(negedge clk_50mhz);
      n += int'(tg.fan_pwm);
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    reset           = 1'b1;
    tg.sample_valid = 1'b0;
    tg.sample_val   = 8'd0;
    tg.trip_clear   = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    chk("rst_avg", 32'(tg.avg_temp), 32'd0);
    chk("rst_avg_valid", 32'(tg.avg_valid), 32'd0);
    chk("rst_fan", 32'(tg.fan_pwm), 32'd0);
    chk("rst_overheat", 32'(tg.overheat), 32'd0);
    chk("rst_stale", 32'(tg.stale), 32'd0);
    reset = 1'b0;

    send(8'd40, 8'd40, "first");
    @(negedge clk_50mhz);
    chk("first_valid_drop", 32'(tg.avg_valid), 32'd0);
    chk("first_overheat", 32'(tg.overheat), 32'd0);
    pwm_count(64, "duty_cool");

    for (int i = 0; i < 3; i++) begin
      tg.sample_val   = 8'd80;
      tg.sample_valid = 1'b1;
      @(negedge clk_50mhz);
      chk("b2b_valid", 32'(tg.avg_valid), 32'd1);
      chk("b2b_avg", 32'(tg.avg_temp), 32'(exp_b2b[i]));
    end
    tg.sample_valid = 1'b0;
    @(negedge clk_50mhz);
    chk("warm_overheat", 32'(tg.overheat), 32'd0);
    pwm_count(160, "duty_warm");

    send(8'd24, 8'd66, "hyst66");
    pwm_count(160, "hyst_hold_warm");
    send(8'd72, 8'd64, "hyst64");
    pwm_count(64, "hyst_drop_cool");

    for (int i = 0; i < 4; i++) begin
      tg.sample_val   = 8'd90;
      tg.sample_valid = 1'b1;
      @(negedge clk_50mhz);
      chk("heat_avg", 32'(tg.avg_temp), 32'(exp_hot[i]));
    end
    tg.sample_valid = 1'b0;
    @(negedge clk_50mhz);
    chk("hot_overheat", 32'(tg.overheat), 32'd1);
    pwm_count(256, "duty_hot");

    tg.trip_clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tg.sample_val   = 8'd82;
      tg.sample_valid = 1'b1;
      @(negedge clk_50mhz);
      chk("clr_avg", 32'(tg.avg_temp), 32'(exp_clr[i]));
      chk("clr_hold_hot", 32'(tg.overheat), 32'd1);
    end
    tg.sample_valid = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    chk("clr_above80_hot", 32'(tg.overheat), 32'd1);
    tg.trip_clear = 1'b0;

    send(8'd70, 8'd79, "cool79");
    send(8'd70, 8'd76, "cool76");
    repeat (20) @(negedge clk_50mhz);
    chk("sticky_hot", 32'(tg.overheat), 32'd1);

    tg.trip_clear = 1'b1;
    @(negedge clk_50mhz);
    chk("hot_exit", 32'(tg.overheat), 32'd0);
    tg.trip_clear = 1'b0;
    pwm_count(160, "exit_to_warm");

    send(8'd20, 8'd60, "drop60");
    pwm_count(64, "warm_to_cool");

    send(8'd200, 8'd90, "direct");
    chk("direct_ovh_n1", 32'(tg.overheat), 32'd0);
    @(negedge clk_50mhz);
    chk("direct_ovh_n2", 32'(tg.overheat), 32'd1);
    repeat (3) @(negedge clk_50mhz);
    chk("direct_fan", 32'(tg.fan_pwm), 32'd1);

    reset = 1'b1;
    @(negedge clk_50mhz);
    chk("midrst_avg", 32'(tg.avg_temp), 32'd0);
    chk("midrst_avg_valid", 32'(tg.avg_valid), 32'd0);
    chk("midrst_fan", 32'(tg.fan_pwm), 32'd0);
    chk("midrst_overheat", 32'(tg.overheat), 32'd0);
    chk("midrst_stale", 32'(tg.stale), 32'd0);
    reset = 1'b0;
    @(negedge clk_50mhz);

    send(8'd30, 8'd30, "post_rst");
    @(negedge clk_50mhz);
    chk("post_rst_overheat", 32'(tg.overheat), 32'd0);
    pwm_count(64, "post_rst_cool");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
